// File: rtl/scan_sequencer_3b_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_pkg
// Description : Shared types and constants for the 3-bit scan sequencer and
//               the 3-to-8 decoder stage that consumes its select index.
// Revision    : 1.0  initial release
// ============================================================================
package scan_pkg;

    localparam int SEL_W   = 3;
    localparam int MAX_IDX = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DWELL = 2'd2
    } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/scan_sequencer_3b_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : scan_down_counter
// Description : Loadable down-counter with a zero flag. It saturates at zero.
//               A load takes priority over a decrement.
// Ports       : clk         system clock, rising edge
//               rst_n       synchronous active-low reset (count -> 0)
//               load_i      load load_val_i on this edge
//               load_val_i  value to load
//               dec_i       decrement by one on this edge (ignored at zero)
//               zero_o      count is zero
// Revision    : 1.0  initial release
// ============================================================================
module scan_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/scan_sequencer_3b.sv
`default_nettype none
// ============================================================================
// Module      : scan_sequencer_3b
// Description : Time-multiplexed scan sequencer. Steps a 3-bit select index
//               0..last_idx, holding each index for dwell+1 cycles, with
//               BLANK_CYCLES of blanking ahead of every digit so the
//               downstream decoder never drives two outputs back to back.
// Ports       : clk          system clock, rising edge
//               rst_n        synchronous active-low reset
//               en           scan enable (level); low aborts to IDLE
//               dwell        dwell length minus one, cycles per digit
//               last_idx     highest index scanned
//               sel          registered select index to the decoder
//               sel_valid    decoder may drive (low in blanking and idle)
//               frame_start  one-cycle pulse at the start of index 0's slot
//               busy         block is not idle
// Revision    : 1.0  initial release
// ============================================================================
module scan_sequencer_3b
    import scan_pkg::*;
#(
    parameter int DWELL_W      = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [SEL_W-1:0]   last_idx,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               frame_start,
    output logic               busy
);

    // The blank counter still needs one bit when blanking is disabled.
    localparam int c_blank_w = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [c_blank_w-1:0] c_blank_load =
        (BLANK_CYCLES > 0) ? c_blank_w'(BLANK_CYCLES - 1) : '0;

    scan_state_e        state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               sel_valid_q, sel_valid_d;
    logic               frame_start_q, frame_start_d;
    logic               busy_q, busy_d;
    logic [DWELL_W-1:0] shadow_dwell_q, shadow_dwell_d;
    logic [SEL_W-1:0]   shadow_last_q, shadow_last_d;

    logic               blank_load, blank_dec, blank_zero;
    logic               dwell_load, dwell_dec, dwell_zero;
    logic [DWELL_W-1:0] dwell_load_val;
    logic               wrap;

    scan_down_counter #(.WIDTH(c_blank_w)) u_blank_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (blank_load),
        .load_val_i (c_blank_load),
        .dec_i      (blank_dec),
        .zero_o     (blank_zero)
    );

    scan_down_counter #(.WIDTH(DWELL_W)) u_dwell_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (dwell_load),
        .load_val_i (dwell_load_val),
        .dec_i      (dwell_dec),
        .zero_o     (dwell_zero)
    );

    // Wrap on the captured limit, and also on a limit lowered during the
    // current dwell, so a shrunk frame wraps at this boundary instead of
    // stepping one index past the new limit first. MAX_IDX guards the
    // increment even though last_idx cannot exceed it.
    assign wrap = (sel_q >= shadow_last_q) || (sel_q >= last_idx) ||
                  (sel_q == SEL_W'(MAX_IDX));

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        frame_start_d  = 1'b0;
        shadow_dwell_d = shadow_dwell_q;
        shadow_last_d  = shadow_last_q;
        blank_load     = 1'b0;
        blank_dec      = 1'b0;
        dwell_load     = 1'b0;
        dwell_dec      = 1'b0;
        dwell_load_val = shadow_dwell_q;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    sel_d          = '0;
                    frame_start_d  = 1'b1;
                    shadow_dwell_d = dwell;
                    shadow_last_d  = last_idx;
                    if (BLANK_CYCLES == 0) begin
                        state_d        = ST_DWELL;
                        dwell_load     = 1'b1;
                        dwell_load_val = dwell;
                    end else begin
                        state_d    = ST_BLANK;
                        blank_load = 1'b1;
                    end
                end
            end
            ST_BLANK: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                end else if (blank_zero) begin
                    state_d    = ST_DWELL;
                    dwell_load = 1'b1;
                end else begin
                    blank_dec = 1'b1;
                end
            end
            ST_DWELL: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                end else if (dwell_zero) begin
                    if (wrap) begin
                        sel_d         = '0;
                        frame_start_d = 1'b1;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                    shadow_dwell_d = dwell;
                    shadow_last_d  = last_idx;
                    if (BLANK_CYCLES == 0) begin
                        state_d        = ST_DWELL;
                        dwell_load     = 1'b1;
                        dwell_load_val = dwell;
                    end else begin
                        state_d    = ST_BLANK;
                        blank_load = 1'b1;
                    end
                end else begin
                    dwell_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        sel_valid_d = (state_d == ST_DWELL);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            sel_q          <= '0;
            sel_valid_q    <= 1'b0;
            frame_start_q  <= 1'b0;
            busy_q         <= 1'b0;
            shadow_dwell_q <= '0;
            shadow_last_q  <= '0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            sel_valid_q    <= sel_valid_d;
            frame_start_q  <= frame_start_d;
            busy_q         <= busy_d;
            shadow_dwell_q <= shadow_dwell_d;
            shadow_last_q  <= shadow_last_d;
        end
    end

    assign sel         = sel_q;
    assign sel_valid   = sel_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_sequencer_3b.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_sequencer_3b
// Description : Scoreboard bench for scan_sequencer_3b. Instance A uses two
//               blanking cycles, instance B uses none. Expected valid slots
//               and frame_start pulses are queued with their cycle numbers;
//               monitors pop and compare whenever the DUTs present them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_scan_sequencer_3b;

    typedef struct {
        int         cyc;
        logic [2:0] sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b;
    logic [15:0] dwell_a, dwell_b;
    logic [2:0]  last_a, last_b;
    logic [2:0]  sel_a, sel_b;
    logic        sv_a, sv_b, fs_a, fs_b, busy_a, busy_b;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t qa_v[$];
    exp_t qb_v[$];
    int   qa_fs[$];
    int   qb_fs[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scan_sequencer_3b #(.DWELL_W(16), .BLANK_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .dwell(dwell_a), .last_idx(last_a),
        .sel(sel_a), .sel_valid(sv_a), .frame_start(fs_a), .busy(busy_a)
    );

    scan_sequencer_3b #(.DWELL_W(16), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .dwell(dwell_b), .last_idx(last_b),
        .sel(sel_b), .sel_valid(sv_b), .frame_start(fs_b), .busy(busy_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step(1);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        exp_t e;
        int   f;
        if (sv_a) begin
            if (qa_v.size() == 0) chk("A_unexpected_valid_sel", int'(sel_a), -1);
            else begin
                e = qa_v.pop_front();
                chk("A_valid_cycle", cyc, e.cyc);
                chk("A_valid_sel", int'(sel_a), int'(e.sel));
            end
        end
        if (fs_a) begin
            if (qa_fs.size() == 0) chk("A_unexpected_frame_start", cyc, -1);
            else begin
                f = qa_fs.pop_front();
                chk("A_frame_start_cycle", cyc, f);
            end
        end
        if (sv_b) begin
            if (qb_v.size() == 0) chk("B_unexpected_valid_sel", int'(sel_b), -1);
            else begin
                e = qb_v.pop_front();
                chk("B_valid_cycle", cyc, e.cyc);
                chk("B_valid_sel", int'(sel_b), int'(e.sel));
            end
        end
        if (fs_b) begin
            if (qb_fs.size() == 0) chk("B_unexpected_frame_start", cyc, -1);
            else begin
                f = qb_fs.pop_front();
                chk("B_frame_start_cycle", cyc, f);
            end
        end
    end

    function automatic void push_a(input int c, input int s);
        exp_t e;
        e.cyc = c;
        e.sel = 3'(s);
        qa_v.push_back(e);
    endfunction

    function automatic void push_b(input int c, input int s);
        exp_t e;
        e.cyc = c;
        e.sel = 3'(s);
        qb_v.push_back(e);
    endfunction

    // Queue one digit slot of instance A (blank 2, dwell 3): valid at
    // slot+2..slot+5, truncated at the last cycle before an abort.
    function automatic void slot_a(input int slot, input int s, input bit fs, input int stop);
        if (fs) qa_fs.push_back(slot);
        for (int k = 0; k < 4; k++)
            if (slot + 2 + k <= stop) push_a(slot + 2 + k, s);
    endfunction

    task automatic chk_idle(input string name);
        chk({name, "_A"}, int'({sel_a, sv_a, fs_a, busy_a}), 0);
        chk({name, "_B"}, int'({sel_b, sv_b, fs_b, busy_b}), 0);
    endtask

    initial begin
        int base;
        int r;
        int b;
        rst_n   = 1'b0;
        en_a    = 1'b1;
        en_b    = 1'b1;
        dwell_a = 16'd3;
        last_a  = 3'd2;
        dwell_b = 16'd0;
        last_b  = 3'd7;

        // Reset held with en=1: outputs stay at reset values.
        step(1);
        repeat (3) begin
            @(negedge clk);
            chk_idle("reset_hold");
        end
        step(1);
        en_a  = 1'b0;
        en_b  = 1'b0;
        rst_n = 1'b1;
        step(2);

        // Normal scan, two full frames plus a partial third, aborted during
        // the sel=1 dwell of that third frame.
        base = cyc;
        en_a = 1'b1;
        for (int f = 0; f < 3; f++)
            for (int d = 0; d < 3; d++)
                if (base + 1 + 18 * f + 6 * d <= base + 46)
                    slot_a(base + 1 + 18 * f + 6 * d, d, d == 0, base + 46);
        step_to(base + 46);
        en_a = 1'b0;
        step(1);
        chk_idle("abort");

        // Re-assert with last_idx=5, then lower it to 1 during the sel=4 dwell.
        step(3);
        r      = cyc;
        en_a   = 1'b1;
        last_a = 3'd5;
        for (int d = 0; d < 5; d++) slot_a(r + 1 + 6 * d, d, d == 0, r + 30);
        slot_a(r + 31, 0, 1'b1, r + 36);
        step_to(r + 28);
        last_a = 3'd1;

        // Reset pulse during the blanking ahead of sel=1.
        step_to(r + 37);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk_idle("sync_reset");
        slot_a(r + 39, 0, 1'b1, r + 42);
        step_to(r + 42);
        en_a = 1'b0;
        step(1);
        chk("end_idle_A", int'({sel_a, sv_a, fs_a, busy_a}), 0);

        // No blanking, one-cycle dwell, full 0..7 scan for three frames.
        step(2);
        b    = cyc;
        en_b = 1'b1;
        for (int c = b + 1; c <= b + 24; c++) begin
            push_b(c, (c - b - 1) % 8);
            if ((c - b - 1) % 8 == 0) qb_fs.push_back(c);
        end
        step_to(b + 24);
        en_b = 1'b0;
        step(1);
        chk("end_idle_B", int'({sel_b, sv_b, fs_b, busy_b}), 0);

        step(3);
        chk("A_valid_left", qa_v.size(), 0);
        chk("A_fs_left", qa_fs.size(), 0);
        chk("B_valid_left", qb_v.size(), 0);
        chk("B_fs_left", qb_fs.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
